// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter.
// State encodings, requester IDs and the default response timeout.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_IFU = 1'b0,
        ARB_LSU = 1'b1
    } arb_id_t;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU.
// One outstanding transaction, response timeout, one-cycle response pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic              ifu_resp_err,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_mask,
    output logic              lsu_resp_valid,
    output logic              lsu_resp_err,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state;
    arb_id_t           last;
    arb_id_t           owner;
    logic [7:0]        cnt;
    logic              grant_ifu;
    logic              grant_lsu;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    // Grant uses only state, pointer and valids so no path from mem_* inputs.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == ARB_IDLE && !rst) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = (last == ARB_IFU);
                grant_ifu = (last == ARB_LSU);
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    always_comb begin
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        if (state == ARB_WAIT) begin
            if (mem_resp_valid) begin
                done      = 1'b1;
                done_data = mem_wen ? '0 : mem_rdata;
            end else if (cnt == TO_LAST) begin
                done     = 1'b1;
                done_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ARB_IDLE;
            last           <= ARB_IFU;
            owner          <= ARB_IFU;
            cnt            <= '0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_mask       <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_err   <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            lsu_rdata      <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_lsu) begin
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wen ? lsu_wdata : '0;
                        mem_mask      <= lsu_wen ? lsu_mask : '0;
                        owner         <= ARB_LSU;
                        last          <= ARB_LSU;
                        mem_req_valid <= 1'b1;
                        state         <= ARB_ISSUE;
                    end else if (grant_ifu) begin
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_mask      <= '0;
                        owner         <= ARB_IFU;
                        last          <= ARB_IFU;
                        mem_req_valid <= 1'b1;
                        state         <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (done) begin
                        state <= ARB_RESP;
                        if (owner == ARB_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_err   <= done_err;
                            lsu_rdata      <= done_data;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_err   <= done_err;
                            ifu_rdata      <= done_data;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ARB_RESP: begin
                    ifu_resp_valid <= 1'b0;
                    ifu_resp_err   <= 1'b0;
                    ifu_rdata      <= '0;
                    lsu_resp_valid <= 1'b0;
                    lsu_resp_err   <= 1'b0;
                    lsu_rdata      <= '0;
                    state          <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
